// File: rtl/warmup2_subtractor.sv
// warmup2_subtractor: pipelined multi-precision subtractor C = A - B - Bin, one LIMB per stage.
// Ports: clk, reset (async, active-high), start/done strobes, A minuend, B subtrahend, Bin borrow-in,
//        M modulus (only with SUB_MODCORR_EN), C difference, Bout final borrow.
// Optional: define SUB_MODCORR_EN to add M and one extra stage computing C + M when the raw borrow is set.
module warmup2_subtractor #(
  parameter int WIDTH = 384,
  parameter int LIMB  = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             Bin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
`ifdef SUB_MODCORR_EN
  input  logic [WIDTH-1:0] M,
`endif
  output logic [WIDTH-1:0] C,
  output logic             Bout,
  output logic             done
);
  localparam int NLIMB = WIDTH / LIMB;
  logic [WIDTH-1:0] a_q [NLIMB];
  logic [WIDTH-1:0] b_q [NLIMB];
  logic [WIDTH-1:0] c_q [NLIMB];
  logic [WIDTH-1:0] c_d [NLIMB];
  logic [WIDTH-1:0] a_s [NLIMB];
  logic [WIDTH-1:0] b_s [NLIMB];
  logic [WIDTH-1:0] c_s [NLIMB];
  logic [NLIMB-1:0] br_q, br_d, bw_s, v_q, v_s;
  logic [LIMB:0] diff;
`ifdef SUB_MODCORR_EN
  logic [WIDTH-1:0] m_q [NLIMB];
  logic [WIDTH-1:0] m_s [NLIMB];
  logic [WIDTH-1:0] cm_q;
  logic bo_q, done_q;
`endif
  // Stage k reads the registers of stage k-1 (stage 0 reads the ports); v_s doubles as the valid shift.
  always_comb begin
    a_s[0] = A;
    b_s[0] = B;
    c_s[0] = '0;
    bw_s[0] = Bin;
    v_s[0] = start;
`ifdef SUB_MODCORR_EN
    m_s[0] = M;
`endif
    for (int k = 1; k < NLIMB; k++) begin
      a_s[k] = a_q[k-1];
      b_s[k] = b_q[k-1];
      c_s[k] = c_q[k-1];
      bw_s[k] = br_q[k-1];
      v_s[k] = v_q[k-1];
`ifdef SUB_MODCORR_EN
      m_s[k] = m_q[k-1];
`endif
    end
    diff = '0;
    br_d = '0;
    for (int k = 0; k < NLIMB; k++) begin
      diff = {1'b0, a_s[k][k*LIMB +: LIMB]} - {1'b0, b_s[k][k*LIMB +: LIMB]} - (LIMB+1)'(bw_s[k]);
      c_d[k] = c_s[k];
      c_d[k][k*LIMB +: LIMB] = diff[LIMB-1:0];
      br_d[k] = diff[LIMB];
    end
  end
  // Data registers load only for valid slots, so C stays 0 after reset until the first result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NLIMB; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= '0;
`ifdef SUB_MODCORR_EN
        m_q[k] <= '0;
`endif
      end
      br_q <= '0;
      v_q <= '0;
    end else begin
      v_q <= v_s;
      for (int k = 0; k < NLIMB; k++) begin
        if (v_s[k]) begin
          a_q[k] <= a_s[k];
          b_q[k] <= b_s[k];
          c_q[k] <= c_d[k];
          br_q[k] <= br_d[k];
`ifdef SUB_MODCORR_EN
          m_q[k] <= m_s[k];
`endif
        end
      end
    end
  end
`ifdef SUB_MODCORR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cm_q <= '0;
      bo_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= v_q[NLIMB-1];
      if (v_q[NLIMB-1]) begin
        cm_q <= br_q[NLIMB-1] ? c_q[NLIMB-1] + m_q[NLIMB-1] : c_q[NLIMB-1];
        bo_q <= br_q[NLIMB-1];
      end
    end
  end
  assign C = cm_q;
  assign Bout = bo_q;
  assign done = done_q;
`else
  assign C = c_q[NLIMB-1];
  assign Bout = br_q[NLIMB-1];
  assign done = v_q[NLIMB-1];
`endif
endmodule

// File: tb/tb_warmup2_subtractor.sv
// tb_warmup2_subtractor: table vectors, reset corner case and random traffic against an arithmetic model.
module tb_warmup2_subtractor;
  localparam int W = 384;
  localparam int L = 128;
  localparam int N = W / L;
`ifdef SUB_MODCORR_EN
  localparam int LAT = N + 1;
`else
  localparam int LAT = N;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic Bin = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] M = W'(97);
  logic [W-1:0] C;
  logic Bout, done;
  typedef struct {logic [W-1:0] c; logic bo; int due;} exp_t;
  typedef struct {logic [W-1:0] a; logic [W-1:0] b; logic bin; logic [W-1:0] c; logic bo;} vec_t;
  exp_t q[$];
  vec_t tbl[6];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  warmup2_subtractor #(.WIDTH(W), .LIMB(L)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .Bin(Bin),
    .A(A),
    .B(B),
`ifdef SUB_MODCORR_EN
    .M(M),
`endif
    .C(C),
    .Bout(Bout),
    .done(done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic void chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, act, exp);
    end
  endfunction
  // Reference: plain wide arithmetic, then the optional modular correction.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    exp_t e;
    logic [W:0] d;
    d = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
    e.c = d[W-1:0];
    e.bo = d[W];
`ifdef SUB_MODCORR_EN
    if (e.bo) e.c = e.c + M;
`endif
    e.due = 0;
    return e;
  endfunction
  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction
  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        chk("done", W'(done), W'(1));
        chk("C", C, q[0].c);
        chk("Bout", W'(Bout), W'(q[0].bo));
        void'(q.pop_front());
      end else chk("idle_done", W'(done), W'(0));
    end
  end
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input logic [W-1:0] c, input logic bo);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    Bin = bin;
    start = 1'b1;
    e.c = c;
    e.bo = bo;
    e.due = cyc + LAT;
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
      A = rnd();
      B = rnd();
      Bin = 1'($urandom);
    end
  endtask
  initial begin
    logic [W-1:0] one, x, ra, rb, mc;
    exp_t e;
    one = W'(1);
    x = one << (W - 1);
    tbl[0] = '{W'(5), W'(3), 1'b0, W'(2), 1'b0};
    tbl[1] = '{W'(0), W'(1), 1'b0, '1, 1'b1};
    tbl[2] = '{one << L, W'(1), 1'b1, (one << L) - W'(2), 1'b0};
    tbl[3] = '{W'(10), W'(4), 1'b0, W'(6), 1'b0};
    tbl[4] = '{W'(4), W'(10), 1'b0, W'(0) - W'(6), 1'b1};
    tbl[5] = '{x, x, 1'b0, W'(0), 1'b0};
    #1;
    chk("rst_C", C, '0);
    chk("rst_Bout", W'(Bout), W'(0));
    chk("rst_done", W'(done), W'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mc = tbl[i].c;
`ifdef SUB_MODCORR_EN
      if (tbl[i].bo) mc = mc + M;
`endif
      issue(tbl[i].a, tbl[i].b, tbl[i].bin, mc, tbl[i].bo);
      if (i < 3) idle(LAT + 1);
    end
    idle(LAT + 2);
`ifdef SUB_MODCORR_EN
    issue(W'(3), W'(10), 1'b0, W'(90), 1'b1);
    issue(W'(10), W'(3), 1'b0, W'(7), 1'b0);
    idle(LAT + 2);
`endif
    issue(rnd(), rnd(), 1'b0, '0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    reset = 1'b1;
    q.delete();
    #1;
    chk("midrst_C", C, '0);
    chk("midrst_Bout", W'(Bout), W'(0));
    chk("midrst_done", W'(done), W'(0));
    @(negedge clk);
    chk("midrst_done2", W'(done), W'(0));
    reset = 1'b0;
    idle(6);
    for (int i = 0; i < 60; i++) begin
      ra = rnd();
      case ($urandom_range(0, 3))
        0: rb = rnd();
        1: rb = ra;
        2: rb = ra + W'(1);
        default: begin
          ra = ra & {N{{L/2{1'b0}}, {L/2{1'b1}}}};
          rb = ra | W'(1);
        end
      endcase
      e = model(ra, rb, 1'($urandom));
      issue(ra, rb, 1'($urandom), '0, 1'b0);
      e = model(ra, rb, Bin);
      q[q.size()-1].c = e.c;
      q[q.size()-1].bo = e.bo;
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(LAT + 3);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results never appeared, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
